// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised synchronous FIFO.
// Read mode is selected with FIFO_FWFT_EN (defined: first-word-fall-through).
package fifo_pkg;

  localparam int FIFO_WIDTH_DEF = 16;
  localparam int FIFO_DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_WR   = 2'd1,
    OP_RD   = 2'd2,
    OP_WRRD = 2'd3
  } fifo_op_e;

  // Explicit wrap so non-power-of-two depths never rely on binary overflow
  function automatic int unsigned next_ptr(
    input int unsigned ptr,
    input int unsigned depth
  );
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for fifo_sync_param: one write port, one read address.
// FIFO_FWFT_EN selects a combinational read path instead of a registered one.
module fifo_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
`ifndef FIFO_FWFT_EN
  input  logic             rst_n,
  input  logic             rd_en,
`endif
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

`ifdef FIFO_FWFT_EN
  assign rd_data = mem[rd_addr];
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end
`endif

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with programmable almost-full/empty flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [CNT_W-1:0]      af_thresh,
  input  logic [CNT_W-1:0]      ae_thresh,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CNT_W-1:0]      count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_ok;
  logic             rd_ok;
  fifo_op_e         op;

  assign full        = (count == CNT_W'(FIFO_DEPTH));
  assign empty       = (count == '0);
  assign almostfull  = (count >= af_thresh);
  assign almostempty = (count <= ae_thresh);

  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_comb begin
    op = OP_IDLE;
    case ({wr_ok, rd_ok})
      2'b10:   op = OP_WR;
      2'b01:   op = OP_RD;
      2'b11:   op = OP_WRRD;
      default: op = OP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ack    <= wr_ok;
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
      if (wr_ok)
        wr_ptr <= PTR_W'(next_ptr(32'(wr_ptr), FIFO_DEPTH));
      if (rd_ok)
        rd_ptr <= PTR_W'(next_ptr(32'(rd_ptr), FIFO_DEPTH));
      case (op)
        OP_WR:   count <= count + CNT_W'(1);
        OP_RD:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  fifo_mem #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .AW    (PTR_W)
  ) u_mem (
    .clk     (clk),
`ifndef FIFO_FWFT_EN
    .rst_n   (rst_n),
    .rd_en   (rd_ok),
`endif
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_addr (rd_ptr),
    .rd_data (data_out)
  );

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed self-checking bench for fifo_sync_param (depth 8 and depth 5).
module tb_fifo_sync_param;
  import fifo_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [15:0] din;
  logic        wr_en;
  logic        rd_en;
  logic [3:0]  af_th;
  logic [3:0]  ae_th;
  logic [15:0] dout;
  logic        wr_ack;
  logic        ovf;
  logic        unf;
  logic        full;
  logic        empty;
  logic        afull;
  logic        aempty;
  logic [3:0]  cnt;

  logic        r5_n;
  logic [15:0] d5_in;
  logic        w5;
  logic        r5;
  logic [2:0]  af5;
  logic [2:0]  ae5;
  logic [15:0] d5_out;
  logic        ack5;
  logic        ovf5;
  logic        unf5;
  logic        full5;
  logic        empty5;
  logic        afull5;
  logic        aempty5;
  logic [2:0]  cnt5;

  int passed = 0;
  int total  = 0;
  logic [15:0] sb [$];
  int          mcnt5 = 0;
  logic [15:0] wval = 16'h0100;
  logic [15:0] exp_d;

  fifo_sync_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (din),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .af_thresh   (af_th),
    .ae_thresh   (ae_th),
    .data_out    (dout),
    .wr_ack      (wr_ack),
    .overflow    (ovf),
    .underflow   (unf),
    .full        (full),
    .empty       (empty),
    .almostfull  (afull),
    .almostempty (aempty),
    .count       (cnt)
  );

  fifo_sync_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(5)) dut5 (
    .clk         (clk),
    .rst_n       (r5_n),
    .data_in     (d5_in),
    .wr_en       (w5),
    .rd_en       (r5),
    .af_thresh   (af5),
    .ae_thresh   (ae5),
    .data_out    (d5_out),
    .wr_ack      (ack5),
    .overflow    (ovf5),
    .underflow   (unf5),
    .full        (full5),
    .empty       (empty5),
    .almostfull  (afull5),
    .almostempty (aempty5),
    .count       (cnt5)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One read on the depth-8 FIFO, checking the returned word in either mode
  task automatic rd8(input logic [15:0] exp);
    rd_en = 1'b1;
`ifdef FIFO_FWFT_EN
    #0 chk("rd8_data", dout, exp);
`endif
    cyc();
`ifndef FIFO_FWFT_EN
    chk("rd8_data", dout, exp);
`endif
    rd_en = 1'b0;
  endtask

  task automatic step5(input logic w, input logic r);
    w5 = w;
    r5 = r;
    d5_in = wval;
    if (r) exp_d = sb[0];
`ifdef FIFO_FWFT_EN
    if (r) chk("d5_data", d5_out, exp_d);
`endif
    cyc();
    if (w) begin
      sb.push_back(wval);
      wval = wval + 16'd1;
    end
    if (r) void'(sb.pop_front());
    mcnt5 = mcnt5 + (w ? 1 : 0) - (r ? 1 : 0);
`ifndef FIFO_FWFT_EN
    if (r) chk("d5_data", d5_out, exp_d);
`endif
    chk("d5_count", cnt5, mcnt5);
    w5 = 1'b0;
    r5 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; r5_n = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0; din = '0;
    w5 = 1'b0; r5 = 1'b0; d5_in = '0;
    af_th = 4'd6; ae_th = 4'd2; af5 = 3'd4; ae5 = 3'd1;
    #1 rst_n = 1'b0; r5_n = 1'b0;
    #1;
    chk("rst_count", cnt, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", afull, 0);
    chk("rst_aempty", aempty, 1);
    chk("rst_wr_ack", wr_ack, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_unf", unf, 0);
`ifndef FIFO_FWFT_EN
    chk("rst_dout", dout, 0);
`endif
    af_th = 4'd0;
    #0 chk("rst_afull_th0", afull, 1);
    af_th = 4'd6;
    #1 rst_n = 1'b1; r5_n = 1'b1;

    // Fill 0 -> 8 and watch the almost flags
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1;
      din = 16'(i);
      cyc();
      chk("fill_ack", wr_ack, 1);
      chk("fill_count", cnt, i);
      chk("fill_afull", afull, (i >= 6) ? 1 : 0);
      chk("fill_aempty", aempty, (i <= 2) ? 1 : 0);
    end
    chk("fill_full", full, 1);
    din = 16'h0009;
    cyc();
    chk("ovf_pulse", ovf, 1);
    chk("ovf_ack", wr_ack, 0);
    chk("ovf_count", cnt, 8);
    wr_en = 1'b0;
    af_th = 4'd9;
    #0 chk("afull_th9", afull, 0);
    af_th = 4'd6;
    cyc();
    chk("ovf_clear", ovf, 0);

    for (int i = 1; i <= 8; i++) begin
      rd8(16'(i));
      chk("drain_count", cnt, 8 - i);
    end
    chk("drain_empty", empty, 1);
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    chk("unf_pulse", unf, 1);
    chk("unf_count", cnt, 0);
`ifndef FIFO_FWFT_EN
    chk("unf_hold", dout, 16'h0008);
`endif
    cyc();
    chk("unf_clear", unf, 0);

    // Simultaneous read/write at empty, full and mid-level
    wr_en = 1'b1; rd_en = 1'b1; din = 16'h0011;
    cyc();
    chk("sim_e_count", cnt, 1);
    chk("sim_e_unf", unf, 1);
    chk("sim_e_ack", wr_ack, 1);
    rd_en = 1'b0;
    for (int i = 2; i <= 8; i++) begin
      din = 16'(16'h0010 + i);
      cyc();
    end
    chk("sim_f_pre", cnt, 8);
    din = 16'h0099;
    rd8(16'h0011);
    wr_en = 1'b0;
    chk("sim_f_count", cnt, 7);
    chk("sim_f_ovf", ovf, 1);
    chk("sim_f_ack", wr_ack, 0);
    rd8(16'h0012);
    rd8(16'h0013);
    rd8(16'h0014);
    chk("sim_m_pre", cnt, 4);
    wr_en = 1'b1; din = 16'h0055;
    rd8(16'h0015);
    chk("sim_m_count", cnt, 4);
    chk("sim_m_ack", wr_ack, 1);
    din = 16'h0056;
    cyc();
    chk("burst_count", cnt, 5);

    // Asynchronous reset in the middle of a write burst
    din = 16'h0057;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", cnt, 0);
    chk("arst_empty", empty, 1);
    chk("arst_ack", wr_ack, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_unf", unf, 0);
    wr_en = 1'b0;
    rst_n = 1'b1;
    cyc();
    chk("arst_hold", cnt, 0);

    wr_en = 1'b1; din = 16'hABCD;
    cyc();
    wr_en = 1'b0;
`ifdef FIFO_FWFT_EN
    chk("fwft_dout", dout, 16'hABCD);
`else
    chk("noread_dout", dout, 16'h0000);
`endif
    rd8(16'hABCD);
    chk("last_empty", empty, 1);

    // Depth 5: wrap-around with occupancy kept between 2 and 4
    step5(1'b1, 1'b0);
    step5(1'b1, 1'b0);
    for (int g = 0; g < 6; g++) begin
      step5(1'b1, 1'b0);
      step5(1'b1, 1'b0);
      step5(1'b1, 1'b1);
      step5(1'b0, 1'b1);
      step5(1'b0, 1'b1);
    end
    chk("d5_writes", wval, 16'h0114);
    step5(1'b0, 1'b1);
    step5(1'b0, 1'b1);
    chk("d5_empty", empty5, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
Parametrised single-clock synchronous FIFO, the next generation of the team's fixed 16x8 FIFO. Adds generic width and depth, non-power-of-two depth support, and runtime-programmable almost-full/almost-empty thresholds. It also has a mode macro for first-word-fall-through reads. It sits between producer and consumer blocks in the datapath and is driven through the FIFO interface by the constrained-random bench.

Parameters:
FIFO_WIDTH, 16, data word width in bits (>=1)
FIFO_DEPTH, 8, number of storage entries (>=2, any integer, power of two not required)
CNT_W, $clog2(FIFO_DEPTH+1), width of count and threshold ports (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
data_in  in  FIFO_WIDTH  write data
wr_en  in  1  write request
rd_en  in  1  read request
af_thresh  in  CNT_W  almost-full threshold
ae_thresh  in  CNT_W  almost-empty threshold
data_out  out  FIFO_WIDTH  read data
wr_ack  out  1  registered pulse: previous-cycle write accepted
overflow  out  1  registered pulse: previous-cycle write rejected (full)
underflow  out  1  registered pulse: previous-cycle read rejected (empty)
full  out  1  count == FIFO_DEPTH
empty  out  1  count == 0
almostfull  out  1  count >= af_thresh
almostempty  out  1  count <= ae_thresh
count  out  CNT_W  current occupancy

Behaviour:
- Reset (rst_n=0, async): wr_ptr=0, rd_ptr=0, count=0, data_out=0, wr_ack=0, overflow=0, underflow=0.
- Reset output values follow: empty=1, full=0, almostfull = (af_thresh==0), almostempty=1.
- Pointers increment modulo FIFO_DEPTH: explicit wrap from FIFO_DEPTH-1 to 0, never binary overflow.
- Write accepted when wr_en && !full. Memory[wr_ptr] <= data_in, wr_ptr advances, wr_ack=1 next cycle.
- Rejected write (wr_en && full): overflow=1 next cycle, memory and count unchanged.
- Read accepted when rd_en && !empty. Default mode: data_out <= memory[rd_ptr] at the edge, giving 1-cycle latency. rd_ptr advances.
- Rejected read (rd_en && empty): underflow=1 next cycle. data_out holds its value.
- Simultaneous wr_en && rd_en:
  - Neither full nor empty: both proceed, count unchanged.
  - Empty: write only, count+1, underflow=1.
  - Full: read only, count-1, overflow=1.
- count: +1 on write-only, -1 on read-only, else hold. It never exceeds FIFO_DEPTH and never goes below 0.
- full, empty, almostfull and almostempty are combinational from count and the threshold ports. Threshold changes take effect in the same cycle.
- Threshold edge cases:
  - af_thresh > FIFO_DEPTH: almostfull never asserts.
  - ae_thresh >= FIFO_DEPTH: almostempty always asserts.
- wr_ack, overflow and underflow are single-cycle pulses, cleared in any cycle without the triggering event.
- Reset mid-operation: all state clears immediately. Contents are discarded (memory array itself is not cleared).

Optional Feature:
- Macro: FIFO_FWFT_EN.
- Defined (first-word-fall-through): data_out is combinational memory[rd_ptr] whenever !empty. rd_en acknowledges and advances the pointer, so data is valid with zero latency. data_out is don't-care when empty.
- Undefined: registered 1-cycle read as above.
- Flags, count and pulse outputs are identical in both modes.

Decomposition:
- Package fifo_pkg holds:
  - constants FIFO_WIDTH_DEF=16 and FIFO_DEPTH_DEF=8
  - a function next_ptr(ptr, depth) for modulo increment
  - typedef enum fifo_op_e {OP_IDLE, OP_WR, OP_RD, OP_WRRD}, shared by RTL and scoreboard
- One sub-module, fifo_mem: a FIFO_WIDTH x FIFO_DEPTH register array with one write port and one read address. It provides the registered read path, or the combinational read path when FIFO_FWFT_EN is defined.

Test Plan:
1. DEPTH=8, reset, then 8 writes of 0x0001..0x0008 -> full=1, count=8. 9th write -> overflow=1, wr_ack=0, count stays 8.
2. Continue from 1: 8 reads -> data_out 0x0001..0x0008 in order, 1 cycle after each rd_en. Then empty=1. Extra read -> underflow=1, data_out holds 0x0008.
3. FIFO_DEPTH=5: 20 writes interleaved with reads keeping count in 2..4 -> pointers wrap 4->0, data order preserved against the scoreboard queue.
4. af_thresh=6, ae_thresh=2: fill 0->8 -> almostempty=1 for count<=2, almostfull=1 from count=6. Set af_thresh=9 -> almostfull=0 at count=8.
5. Simultaneous wr_en=rd_en=1 at empty -> count 0->1, underflow=1. At full -> count 8->7, overflow=1. At count=4 -> count stays 4, wr_ack=1.
6. rst_n=0 asserted asynchronously mid-burst at count=5 -> count=0, empty=1, pulses 0 before the next edge. With FIFO_FWFT_EN: write 0xABCD into empty -> data_out=0xABCD next cycle without rd_en.
